// File: rtl/rivyera_reg_initiator_if.sv
// Local request/response API and RIVYERA packet-port signals of the register initiator.
// master = the initiator itself, slave = the surrounding user logic and API FIFOs.
interface rivyera_reg_initiator_if #(
    parameter int SLOT_W = 4,
    parameter int FPGA_W = 4,
    parameter int REG_W  = 8,
    parameter int CMD_W  = 4,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rd;
    logic [SLOT_W-1:0] req_slot;
    logic [FPGA_W-1:0] req_fpga;
    logic [REG_W-1:0]  req_reg;
    logic [7:0]        req_cnt;
    logic [DATA_W-1:0] req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    logic              done;
    logic              timeout_err;
    logic [7:0]        drop_cnt;

    logic              api_o_rfd_in;
    logic              api_o_wr_en_out;
    logic [SLOT_W-1:0] api_o_tgt_slot_out;
    logic [FPGA_W-1:0] api_o_tgt_fpga_out;
    logic [REG_W-1:0]  api_o_tgt_reg_out;
    logic [CMD_W-1:0]  api_o_tgt_cmd_out;
    logic [REG_W-1:0]  api_o_src_reg_out;
    logic [CMD_W-1:0]  api_o_src_cmd_out;
    logic [DATA_W-1:0] api_o_data_out;

    logic [SLOT_W-1:0] api_i_src_slot_in;
    logic [FPGA_W-1:0] api_i_src_fpga_in;
    logic [REG_W-1:0]  api_i_tgt_reg_in;
    logic [CMD_W-1:0]  api_i_tgt_cmd_in;
    logic [DATA_W-1:0] api_i_data_in;
    logic              api_i_empty_in;
    logic              api_i_rd_en_out;

    modport master (
        input  req_valid, req_rd, req_slot, req_fpga, req_reg, req_cnt, req_data,
        output req_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output done, timeout_err, drop_cnt,
        input  api_o_rfd_in,
        output api_o_wr_en_out, api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
        output api_o_tgt_cmd_out, api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out,
        input  api_i_src_slot_in, api_i_src_fpga_in, api_i_tgt_reg_in, api_i_tgt_cmd_in,
        input  api_i_data_in, api_i_empty_in,
        output api_i_rd_en_out
    );

    modport slave (
        output req_valid, req_rd, req_slot, req_fpga, req_reg, req_cnt, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  done, timeout_err, drop_cnt,
        output api_o_rfd_in,
        input  api_o_wr_en_out, api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
        input  api_o_tgt_cmd_out, api_o_src_reg_out, api_o_src_cmd_out, api_o_data_out,
        output api_i_src_slot_in, api_i_src_fpga_in, api_i_tgt_reg_in, api_i_tgt_cmd_in,
        output api_i_data_in, api_i_empty_in,
        input  api_i_rd_en_out
    );
endinterface

// File: rtl/rivyera_reg_initiator.sv
// Single-outstanding remote register read/write initiator on the RIVYERA packet API.
// Reads return through local register RSP_REG; unrelated input words are drained and counted.
module rivyera_reg_initiator #(
    parameter int               SLOT_W  = 4,
    parameter int               FPGA_W  = 4,
    parameter int               REG_W   = 8,
    parameter int               CMD_W   = 4,
    parameter int               DATA_W  = 64,
    parameter logic [CMD_W-1:0] CMD_WR  = 4'd1,
    parameter logic [CMD_W-1:0] CMD_RD  = 4'd2,
    parameter logic [REG_W-1:0] RSP_REG = 8'h01,
    parameter int               TO_CYC  = 32'd1024
) (
    input  logic                    clk,
    input  logic                    rst,
    rivyera_reg_initiator_if.master bus
);
    localparam int TMR_W = $clog2(TO_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [SLOT_W-1:0] r_slot;
    logic [FPGA_W-1:0] r_fpga;
    logic [REG_W-1:0]  r_reg;
    logic              r_rd;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [7:0]        r_remaining;
    logic [TMR_W-1:0]  r_timer;
    logic              r_done;
    logic              r_timeout;
    logic [7:0]        r_drop_cnt;

    logic w_match;
    logic w_hit;
    logic w_pop;
    logic w_pop_hit;
    logic w_drop;
    logic w_strobe;

    // Input-head classification and pop/strobe decisions for the current cycle
    always_comb begin
        w_match   = (bus.api_i_src_slot_in == r_slot) &&
                    (bus.api_i_src_fpga_in == r_fpga) &&
                    (bus.api_i_tgt_reg_in  == RSP_REG) &&
                    (bus.api_i_tgt_cmd_in  == CMD_WR);
        w_hit     = (r_state == ST_WAIT) && !bus.api_i_empty_in && w_match;
        // A deliverable word waits for rsp_ready; everything else is drained at once
        w_pop     = !bus.api_i_empty_in && (!w_hit || bus.rsp_ready);
        w_pop_hit = w_hit && bus.rsp_ready;
        w_drop    = w_pop && !w_hit;
        w_strobe  = (r_state == ST_SEND) && bus.api_o_rfd_in;
    end

    assign bus.req_ready          = (r_state == ST_IDLE);
    assign bus.api_o_wr_en_out    = w_strobe;
    assign bus.api_o_tgt_slot_out = r_slot;
    assign bus.api_o_tgt_fpga_out = r_fpga;
    assign bus.api_o_tgt_reg_out  = r_reg;
    assign bus.api_o_tgt_cmd_out  = r_rd ? CMD_RD : CMD_WR;
    assign bus.api_o_src_reg_out  = RSP_REG;
    assign bus.api_o_src_cmd_out  = CMD_WR;
    assign bus.api_o_data_out     = r_rd ? {{(DATA_W-8){1'b0}}, r_cnt} : r_data;
    assign bus.api_i_rd_en_out    = w_pop;
    assign bus.rsp_valid          = w_hit;
    assign bus.rsp_data           = bus.api_i_data_in;
    assign bus.rsp_last           = w_hit && (r_remaining == 8'd1);
    assign bus.done               = r_done;
    assign bus.timeout_err        = r_timeout;
    assign bus.drop_cnt           = r_drop_cnt;

    // Transaction FSM with captured request fields, response counting and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_fpga      <= '0;
            r_reg       <= '0;
            r_rd        <= 1'b0;
            r_cnt       <= 8'd0;
            r_data      <= '0;
            r_remaining <= 8'd0;
            r_timer     <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_slot  <= bus.req_slot;
                        r_fpga  <= bus.req_fpga;
                        r_reg   <= bus.req_reg;
                        r_rd    <= bus.req_rd;
                        r_cnt   <= bus.req_cnt;
                        r_data  <= bus.req_data;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_strobe) begin
                        if (r_rd && (r_cnt != 8'd0)) begin
                            r_remaining <= r_cnt;
                            r_timer     <= '0;
                            r_state     <= ST_WAIT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_pop_hit) begin
                        r_remaining <= r_remaining - 8'd1;
                        r_timer     <= '0;
                        if (r_remaining == 8'd1) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_timer == TMR_W'(TO_CYC - 32'd1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(32'd1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
